// File: rtl/sid_reg_sequencer.sv
// Buffered SID register bus initiator: queues timed register commands and
// issues them as ce_1m-aligned write strobes or read accesses.
module sid_reg_sequencer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WAIT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce_1m,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rd,
  input  logic [4:0]                    cmd_addr,
  input  logic [7:0]                    cmd_data,
  input  logic [WAIT_W-1:0]             cmd_wait,
  input  logic                          pause,
  input  logic                          flush,
  output logic                          sid_we,
  output logic [4:0]                    sid_addr,
  output logic [7:0]                    sid_wdata,
  input  logic [7:0]                    sid_rdata,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = 14 + WAIT_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic               sid_we_q, sid_we_d;
  logic [4:0]         sid_addr_q, sid_addr_d;
  logic [7:0]         sid_wdata_q, sid_wdata_d;
  logic               rd_valid_q, rd_valid_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  logic               full, push, pop;
  logic [ENT_W-1:0]   head;
  logic               head_rd;
  logic [4:0]         head_addr;
  logic [7:0]         head_data;
  logic [WAIT_W-1:0]  head_wait;

  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign cmd_ready = ~full & ~flush & ~reset;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == ST_IDLE) & ce_1m & (level_q != '0) & ~pause & ~flush;

  assign head      = mem_q[rd_ptr_q];
  assign head_rd   = head[ENT_W-1];
  assign head_addr = head[ENT_W-2 -: 5];
  assign head_data = head[WAIT_W+7 -: 8];
  assign head_wait = head[WAIT_W-1:0];

  // Storage needs no reset: only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rd, cmd_addr, cmd_data, cmd_wait};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q;
    if (push && !pop) level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rd_pend_d   = rd_pend_q;
    sid_we_d    = 1'b0;
    sid_addr_d  = sid_addr_q;
    sid_wdata_d = sid_wdata_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d     = ST_ISSUE;
          sid_addr_d  = head_addr;
          sid_wdata_d = head_data;
          sid_we_d    = ~head_rd;
          wait_cnt_d  = head_wait;
          rd_pend_d   = head_rd;
        end
      end
      ST_ISSUE: begin
        // sid_rdata is combinational on sid_addr, which is stable during ISSUE.
        if (rd_pend_q) begin
          rd_data_d  = sid_rdata;
          rd_valid_d = 1'b1;
        end
        rd_pend_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (ce_1m) begin
          if (wait_cnt_q == '0) state_d = ST_IDLE;
          else wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d    = ST_IDLE;
      sid_we_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wait_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      sid_we_q    <= 1'b0;
      sid_addr_q  <= '0;
      sid_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_pend_q   <= rd_pend_d;
      sid_we_q    <= sid_we_d;
      sid_addr_q  <= sid_addr_d;
      sid_wdata_q <= sid_wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign sid_we     = sid_we_q;
  assign sid_addr   = sid_addr_q;
  assign sid_wdata  = sid_wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign busy       = (level_q != '0) | (state_q != ST_IDLE);
  assign fifo_level = level_q;
endmodule

// File: tb/tb_sid_reg_sequencer.sv
// Self-checking bench for sid_reg_sequencer: directed scenarios plus a randomized
// command stream checked against a tick-schedule reference model.
`timescale 1ns/1ps
module tb_sid_reg_sequencer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WW    = 16;

  logic          clk = 1'b0;
  logic          reset, ce_1m, cmd_valid, cmd_ready, cmd_rd, pause, flush;
  logic [4:0]    cmd_addr, sid_addr;
  logic [7:0]    cmd_data, sid_wdata, sid_rdata, rd_data;
  logic [WW-1:0] cmd_wait;
  logic          sid_we, rd_valid, busy;
  logic [4:0]    fifo_level;

  sid_reg_sequencer #(.FIFO_DEPTH(DEPTH), .WAIT_W(WW)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_wait(cmd_wait), .pause(pause), .flush(flush),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_wdata(sid_wdata),
    .sid_rdata(sid_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // SID register file model for reads
  logic [7:0] rmem [32];
  assign sid_rdata = rmem[sid_addr];

  int asserts = 0, failures = 0;
  bit ce_run = 1'b0;
  int ce_div = 4, ce_phase = 0;
  int ticks = 0, cyc = 0, last_ce_cyc = 0, we_wide = 0;
  bit prev_we = 1'b0;

  typedef struct {
    int         tick;
    bit         rd;
    logic [4:0] addr;
    logic [7:0] val;
    int         delta;
  } ev_t;
  ev_t evq[$];

  initial begin
    ce_1m = 1'b0;
    forever begin
      @(posedge clk); #2;
      ce_1m = (ce_run && ce_phase == 0);
      ce_phase = (ce_phase + 1) % ce_div;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (ce_1m === 1'b1) begin ticks++; last_ce_cyc = cyc; end
  end

  initial forever begin
    ev_t e;
    @(negedge clk);
    if (sid_we === 1'b1) begin
      e.tick = ticks; e.rd = 1'b0; e.addr = sid_addr; e.val = sid_wdata; e.delta = cyc - last_ce_cyc;
      evq.push_back(e);
      if (prev_we) we_wide++;
    end
    if (rd_valid === 1'b1) begin
      e.tick = ticks; e.rd = 1'b1; e.addr = sid_addr; e.val = rd_data; e.delta = cyc - last_ce_cyc;
      evq.push_back(e);
    end
    prev_we = (sid_we === 1'b1);
  end

  task automatic tick_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cmd(input bit rd, input logic [4:0] a, input logic [7:0] d, input int w);
    int n = 0;
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_data = d; cmd_wait = WW'(w);
    #1;
    while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      asserts++; failures++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int t = ticks;
    int c = 0;
    while (ticks < t + n && c < n * ce_div * 4 + 100) begin @(negedge clk); c++; end
    if (ticks < t + n) begin
      asserts++; failures++;
      $display("FAIL wait_ticks_timeout: ticks=%0d required %0d", ticks, t + n);
    end
  endtask

  task automatic wait_idle(output int t_fall);
    int c = 0;
    while (busy !== 1'b0 && c < 20000) begin @(negedge clk); c++; end
    t_fall = ticks;
    if (busy !== 1'b0) begin
      asserts++; failures++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic quiesce();
    ce_run = 1'b0;
    tick_clk(2 * ce_div);
    evq.delete();
    we_wide = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce_run = 1'b1;
    tick_clk(3);
    asserts++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b required 0", cmd_ready); end
    reset = 1'b0;
    @(negedge clk);
    asserts++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    asserts++;
    if ({sid_we, sid_addr, sid_wdata} !== 14'd0) begin
      failures++; $display("FAIL reset_sid: got %b/%h/%h required 0/00/00", sid_we, sid_addr, sid_wdata);
    end
    asserts++;
    if ({rd_valid, rd_data, busy, fifo_level} !== 15'd0) begin
      failures++; $display("FAIL reset_misc: got %b/%h/%b/%0d required all 0", rd_valid, rd_data, busy, fifo_level);
    end
  endtask

  task automatic test_single_write();
    int t0, tf;
    quiesce();
    push_cmd(1'b0, 5'h18, 8'h0F, 0);
    t0 = ticks; ce_run = 1'b1;
    wait_idle(tf);
    asserts++;
    if (evq.size() != 1) begin failures++; $display("FAIL single_count: got %0d required 1", evq.size()); end
    else begin
      asserts++;
      if (evq[0].rd || evq[0].addr !== 5'h18 || evq[0].val !== 8'h0F) begin
        failures++; $display("FAIL single_data: got rd=%b %h=%h required wr 18=0f", evq[0].rd, evq[0].addr, evq[0].val);
      end
      asserts++;
      if (evq[0].tick != t0 + 1 || evq[0].delta != 0) begin
        failures++; $display("FAIL single_timing: got tick %0d delta %0d required %0d/0", evq[0].tick, evq[0].delta, t0 + 1);
      end
    end
    asserts++;
    if (we_wide != 0) begin failures++; $display("FAIL single_width: got %0d wide strobes required 0", we_wide); end
    asserts++;
    if (tf != t0 + 2) begin failures++; $display("FAIL single_busy_fall: got tick %0d required %0d", tf, t0 + 2); end
  endtask

  task automatic test_three_writes();
    logic [4:0] a [3] = '{5'h00, 5'h01, 5'h04};
    logic [7:0] d [3] = '{8'h11, 8'h22, 8'h41};
    int         w [3] = '{0, 3, 0};
    int t0, tf, exp_t;
    quiesce();
    for (int i = 0; i < 3; i++) push_cmd(1'b0, a[i], d[i], w[i]);
    t0 = ticks; ce_run = 1'b1;
    wait_idle(tf);
    asserts++;
    if (evq.size() != 3) begin failures++; $display("FAIL three_count: got %0d required 3", evq.size()); end
    else begin
      exp_t = t0 + 1;
      for (int i = 0; i < 3; i++) begin
        asserts++;
        if (evq[i].rd || evq[i].addr !== a[i] || evq[i].val !== d[i] || evq[i].tick != exp_t) begin
          failures++;
          $display("FAIL three_ev%0d: got %h=%h @%0d required %h=%h @%0d", i, evq[i].addr, evq[i].val, evq[i].tick, a[i], d[i], exp_t);
        end
        exp_t = exp_t + 2 + w[i];
      end
    end
  endtask

  task automatic test_full();
    int t0, c;
    quiesce();
    for (int i = 0; i < 16; i++) push_cmd(1'b0, 5'(i), 8'(8'h80 + i), 0);
    asserts++;
    if (fifo_level !== 5'd16 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL full_state: got level %0d ready %b required 16/0", fifo_level, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 5'h1F; cmd_data = 8'hEE; cmd_wait = '0;
    tick_clk(5);
    cmd_valid = 1'b0;
    asserts++;
    if (fifo_level !== 5'd16) begin failures++; $display("FAIL full_overflow: got level %0d required 16", fifo_level); end
    t0 = ticks; ce_run = 1'b1; c = 0;
    while (ticks < t0 + 1 && c < 100) begin @(negedge clk); c++; end
    ce_run = 1'b0;
    asserts++;
    if (fifo_level !== 5'd15 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL full_pop: got level %0d ready %b required 15/1", fifo_level, cmd_ready);
    end
    tick_clk(2);
    asserts++;
    if (evq.size() != 1 || evq[0].addr !== 5'h00 || evq[0].val !== 8'h80) begin
      failures++; $display("FAIL full_first: got %0d events required one write 00=80", evq.size());
    end
    flush = 1'b1; tick_clk(1); flush = 1'b0; tick_clk(1);
    asserts++;
    if (fifo_level !== 5'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL full_flush: got level %0d busy %b required 0/0", fifo_level, busy);
    end
  endtask

  task automatic test_read();
    int tf;
    quiesce();
    push_cmd(1'b1, 5'h1B, 8'h3C, 0);
    ce_run = 1'b1;
    wait_idle(tf);
    asserts++;
    if (evq.size() != 1) begin failures++; $display("FAIL read_count: got %0d events required 1", evq.size()); end
    else begin
      asserts++;
      if (!evq[0].rd || evq[0].val !== 8'hA5 || evq[0].delta != 1 || evq[0].addr !== 5'h1B) begin
        failures++; $display("FAIL read_ev: got rd=%b %h=%h delta %0d required rd 1b=a5 delta 1", evq[0].rd, evq[0].addr, evq[0].val, evq[0].delta);
      end
    end
    tick_clk(3);
    asserts++;
    if (rd_data !== 8'hA5) begin failures++; $display("FAIL read_hold: got %h required a5", rd_data); end
  endtask

  task automatic test_pause();
    int t0, tf;
    quiesce();
    ce_run = 1'b1; pause = 1'b1;
    push_cmd(1'b0, 5'h05, 8'h55, 1);
    push_cmd(1'b0, 5'h06, 8'h66, 0);
    wait_ticks(8);
    asserts++;
    if (evq.size() != 0 || fifo_level !== 5'd2) begin
      failures++; $display("FAIL pause_hold: got %0d events level %0d required 0/2", evq.size(), fifo_level);
    end
    pause = 1'b0; t0 = ticks;
    wait_idle(tf);
    asserts++;
    if (evq.size() != 2) begin failures++; $display("FAIL pause_count: got %0d required 2", evq.size()); end
    else begin
      asserts++;
      if (evq[0].addr !== 5'h05 || evq[0].val !== 8'h55 || evq[0].tick != t0 + 1 ||
          evq[1].addr !== 5'h06 || evq[1].val !== 8'h66 || evq[1].tick != t0 + 4) begin
        failures++;
        $display("FAIL pause_release: got %h=%h@%0d %h=%h@%0d required 05=55@%0d 06=66@%0d",
                 evq[0].addr, evq[0].val, evq[0].tick, evq[1].addr, evq[1].val, evq[1].tick, t0 + 1, t0 + 4);
      end
    end
  endtask

  task automatic test_flush_wait();
    int c = 0;
    int tf;
    quiesce();
    ce_run = 1'b1;
    push_cmd(1'b0, 5'h02, 8'h22, 1000);
    for (int i = 0; i < 5; i++) push_cmd(1'b0, 5'(3 + i), 8'(8'h30 + i), 0);
    while (evq.size() == 0 && c < 200) begin @(negedge clk); c++; end
    wait_ticks(5);
    asserts++;
    if (fifo_level !== 5'd5 || evq.size() != 1) begin
      failures++; $display("FAIL flush_pre: got level %0d events %0d required 5/1", fifo_level, evq.size());
    end
    flush = 1'b1; #1;
    asserts++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b required 0", cmd_ready); end
    @(negedge clk); flush = 1'b0;
    asserts++;
    if (fifo_level !== 5'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_clear: got level %0d busy %b required 0/0", fifo_level, busy);
    end
    wait_ticks(20);
    asserts++;
    if (evq.size() != 1) begin failures++; $display("FAIL flush_quiet: got %0d events required 1", evq.size()); end
    push_cmd(1'b0, 5'h09, 8'h99, 0);
    wait_idle(tf);
    asserts++;
    if (evq.size() != 2 || evq[evq.size()-1].addr !== 5'h09 || evq[evq.size()-1].val !== 8'h99) begin
      failures++; $display("FAIL flush_resume: got %0d events required 2 ending 09=99", evq.size());
    end
  endtask

  task automatic test_flush_read();
    int c = 0;
    quiesce();
    push_cmd(1'b1, 5'h1B, 8'h00, 0);
    ce_run = 1'b1;
    while (fifo_level !== 5'd0 && c < 100) begin @(negedge clk); c++; end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    tick_clk(10);
    asserts++;
    if (evq.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_read: got %0d events busy %b required 0/0", evq.size(), busy);
    end
  endtask

  task automatic test_reset_midwait();
    int c = 0;
    quiesce();
    ce_run = 1'b1;
    push_cmd(1'b0, 5'h0C, 8'hC3, 1000);
    push_cmd(1'b0, 5'h0D, 8'hD4, 0);
    while (evq.size() == 0 && c < 200) begin @(negedge clk); c++; end
    wait_ticks(3);
    reset = 1'b1;
    @(negedge clk);
    asserts++;
    if ({sid_we, sid_addr, sid_wdata, busy, fifo_level, cmd_ready} !== 21'd0) begin
      failures++; $display("FAIL reset_mid: got we %b addr %h data %h busy %b level %0d required all 0",
                           sid_we, sid_addr, sid_wdata, busy, fifo_level);
    end
    reset = 1'b0;
    wait_ticks(6);
    asserts++;
    if (evq.size() != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_quiet: got %0d events busy %b required 1/0", evq.size(), busy);
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    bit         r_rd [N];
    logic [4:0] r_a [N];
    logic [7:0] r_d [N];
    int         r_w [N];
    logic [7:0] exp_v;
    int tf;
    quiesce();
    ce_run = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_rd[i] = 1'($urandom_range(0, 1));
      r_a[i]  = 5'($urandom_range(0, 31));
      r_d[i]  = 8'($urandom);
      r_w[i]  = $urandom_range(0, 3);
    end
    for (int i = 0; i < N; i++) begin
      push_cmd(r_rd[i], r_a[i], r_d[i], r_w[i]);
      tick_clk($urandom_range(0, 6));
    end
    wait_idle(tf);
    asserts++;
    if (evq.size() != N) begin failures++; $display("FAIL rand_count: got %0d required %0d", evq.size(), N); end
    else begin
      for (int i = 0; i < N; i++) begin
        exp_v = r_rd[i] ? rmem[r_a[i]] : r_d[i];
        asserts++;
        if (evq[i].rd != r_rd[i] || evq[i].addr !== r_a[i] || evq[i].val !== exp_v || evq[i].delta != int'(r_rd[i])) begin
          failures++;
          $display("FAIL rand_ev%0d: got rd=%b %h=%h d%0d required rd=%b %h=%h d%0d", i, evq[i].rd, evq[i].addr,
                   evq[i].val, evq[i].delta, r_rd[i], r_a[i], exp_v, int'(r_rd[i]));
        end
        if (i > 0) begin
          asserts++;
          if (evq[i].tick < evq[i-1].tick + 2 + r_w[i-1]) begin
            failures++; $display("FAIL rand_spacing%0d: got tick %0d required >= %0d", i, evq[i].tick, evq[i-1].tick + 2 + r_w[i-1]);
          end
        end
      end
    end
    asserts++;
    if (we_wide != 0) begin failures++; $display("FAIL rand_width: got %0d wide strobes required 0", we_wide); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_wait = '0; pause = 1'b0; flush = 1'b0;
    for (int i = 0; i < 32; i++) rmem[i] = 8'($urandom);
    rmem[27] = 8'hA5;
    test_reset();
    test_single_write();
    test_three_writes();
    test_full();
    test_read();
    test_pause();
    test_flush_wait();
    test_flush_read();
    test_reset_midwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
